// File: rtl/cla_pipe_add.sv
// ============================================================================
// Module   : cla_pipe_add
// Purpose  : Pipelined two-level carry-lookahead adder/subtractor with a
//            valid/ready stream interface. Bits are grouped GROUP at a time
//            into group generate/propagate blocks. A second-level lookahead
//            network then forms every group carry-in.
// Ports    : clk, rst_n (async, active-low)
//            in_valid/in_ready, a, b, cin, sub    - operand stream
//            out_valid/out_ready, sum, cout, gg,
//            pg, ovf                              - result stream
// Params   : WIDTH (multiple of GROUP), GROUP, STAGES (1..3 = latency)
// Options  : CLA_PIPE_SAT_EN - when defined, an overflowing result clamps to
//            signed max/min instead of wrapping.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cla_pipe_add #(
    parameter int WIDTH  = 16,
    parameter int GROUP  = 4,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             gg,
    output logic             pg,
    output logic             ovf
);

    localparam int NG  = WIDTH / GROUP;
    localparam int MSB = WIDTH - 1;

    // ------------------------------------------------------------------
    // Elastic control: one valid bit per register stage. A stage may load
    // when it is empty or when its contents move on downstream.
    // ------------------------------------------------------------------
    logic [STAGES-1:0] v;
    logic [STAGES-1:0] adv;

    always_comb begin : p_adv
        logic nxt;
        adv = '0;
        nxt = !v[STAGES-1] | out_ready;
        adv[STAGES-1] = nxt;
        for (int i = STAGES - 2; i >= 0; i--) begin
            nxt    = !v[i] | nxt;
            adv[i] = nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v <= '0;
        end else begin
            if (adv[0]) v[0] <= in_valid;
            for (int i = 1; i < STAGES; i++) begin
                if (adv[i]) v[i] <= v[i-1];
            end
        end
    end

    assign in_ready  = adv[0];
    assign out_valid = v[STAGES-1];

    // ------------------------------------------------------------------
    // Front: effective operands, bit G/P, group G/P
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] s0_be, s0_g, s0_p;
    logic             s0_ce;
    logic [NG-1:0]    s0_gg, s0_pg;

    assign s0_be = sub ? ~b : b;
    assign s0_ce = sub | cin;
    assign s0_g  = a & s0_be;
    assign s0_p  = a | s0_be;

    always_comb begin
        s0_gg = '0;
        s0_pg = '0;
        for (int j = 0; j < NG; j++) begin
            logic gacc, pacc;
            gacc = 1'b0;
            pacc = 1'b1;
            for (int k = 0; k < GROUP; k++) begin
                gacc = s0_g[j*GROUP+k] | (s0_p[j*GROUP+k] & gacc);
                pacc = pacc & s0_p[j*GROUP+k];
            end
            s0_gg[j] = gacc;
            s0_pg[j] = pacc;
        end
    end

    logic [WIDTH-1:0] s1_a, s1_be, s1_g, s1_p;
    logic             s1_ce;
    logic [NG-1:0]    s1_gg, s1_pg;

    generate
        if (STAGES >= 2) begin : g_reg1
            logic [WIDTH-1:0] r_a, r_be, r_g, r_p;
            logic             r_ce;
            logic [NG-1:0]    r_gg, r_pg;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_a  <= '0;
                    r_be <= '0;
                    r_g  <= '0;
                    r_p  <= '0;
                    r_ce <= 1'b0;
                    r_gg <= '0;
                    r_pg <= '0;
                end else if (adv[0]) begin
                    r_a  <= a;
                    r_be <= s0_be;
                    r_g  <= s0_g;
                    r_p  <= s0_p;
                    r_ce <= s0_ce;
                    r_gg <= s0_gg;
                    r_pg <= s0_pg;
                end
            end

            assign s1_a  = r_a;
            assign s1_be = r_be;
            assign s1_g  = r_g;
            assign s1_p  = r_p;
            assign s1_ce = r_ce;
            assign s1_gg = r_gg;
            assign s1_pg = r_pg;
        end else begin : g_comb1
            assign s1_a  = a;
            assign s1_be = s0_be;
            assign s1_g  = s0_g;
            assign s1_p  = s0_p;
            assign s1_ce = s0_ce;
            assign s1_gg = s0_gg;
            assign s1_pg = s0_pg;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Second level: carry into group n written out as a flat sum of
    // products (each group generate ANDed with the propagates above it),
    // so every group carry is two logic levels deep in group terms.
    // ------------------------------------------------------------------
    function automatic logic la_carry(input logic [NG-1:0] ggv,
                                      input logic [NG-1:0] pgv,
                                      input logic          c0,
                                      input int            n);
        logic c, t;
        c = c0;
        for (int i = 0; i < NG; i++) begin
            if (i < n) c = c & pgv[i];
        end
        for (int i = 0; i < NG; i++) begin
            if (i < n) begin
                t = ggv[i];
                for (int k = 0; k < NG; k++) begin
                    if (k > i && k < n) t = t & pgv[k];
                end
                c = c | t;
            end
        end
        return c;
    endfunction

    logic [NG-1:0] m_gc;
    logic          m_gg, m_pg, m_cout;

    always_comb begin
        m_gc = '0;
        for (int j = 0; j < NG; j++) begin
            m_gc[j] = la_carry(s1_gg, s1_pg, s1_ce, j);
        end
        m_gg   = la_carry(s1_gg, s1_pg, 1'b0, NG);
        m_pg   = &s1_pg;
        m_cout = m_gg | (m_pg & s1_ce);
    end

    logic [WIDTH-1:0] s2_a, s2_be, s2_g, s2_p;
    logic [NG-1:0]    s2_gc;
    logic             s2_gg, s2_pg, s2_cout;

    generate
        if (STAGES == 3) begin : g_reg2
            logic [WIDTH-1:0] r_a, r_be, r_g, r_p;
            logic [NG-1:0]    r_gc;
            logic             r_gg, r_pg, r_cout;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_a    <= '0;
                    r_be   <= '0;
                    r_g    <= '0;
                    r_p    <= '0;
                    r_gc   <= '0;
                    r_gg   <= 1'b0;
                    r_pg   <= 1'b0;
                    r_cout <= 1'b0;
                end else if (adv[1]) begin
                    r_a    <= s1_a;
                    r_be   <= s1_be;
                    r_g    <= s1_g;
                    r_p    <= s1_p;
                    r_gc   <= m_gc;
                    r_gg   <= m_gg;
                    r_pg   <= m_pg;
                    r_cout <= m_cout;
                end
            end

            assign s2_a    = r_a;
            assign s2_be   = r_be;
            assign s2_g    = r_g;
            assign s2_p    = r_p;
            assign s2_gc   = r_gc;
            assign s2_gg   = r_gg;
            assign s2_pg   = r_pg;
            assign s2_cout = r_cout;
        end else begin : g_comb2
            assign s2_a    = s1_a;
            assign s2_be   = s1_be;
            assign s2_g    = s1_g;
            assign s2_p    = s1_p;
            assign s2_gc   = m_gc;
            assign s2_gg   = m_gg;
            assign s2_pg   = m_pg;
            assign s2_cout = m_cout;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Back: in-group carries from each group carry-in, sum bits, overflow
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] f_sum, f_res;
    logic             f_ovf;

    always_comb begin
        f_sum = '0;
        for (int j = 0; j < NG; j++) begin
            logic c;
            c = s2_gc[j];
            for (int k = 0; k < GROUP; k++) begin
                f_sum[j*GROUP+k] = s2_a[j*GROUP+k] ^ s2_be[j*GROUP+k] ^ c;
                c = s2_g[j*GROUP+k] | (s2_p[j*GROUP+k] & c);
            end
        end
        // Overflow is judged on the raw wrapped sum, before any clamping.
        f_ovf = (s2_a[MSB] == s2_be[MSB]) && (f_sum[MSB] != s2_a[MSB]);
`ifdef CLA_PIPE_SAT_EN
        if (f_ovf)
            f_res = s2_a[MSB] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        else
            f_res = f_sum;
`else
        f_res = f_sum;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum  <= '0;
            cout <= 1'b0;
            gg   <= 1'b0;
            pg   <= 1'b0;
            ovf  <= 1'b0;
        end else if (adv[STAGES-1]) begin
            sum  <= f_res;
            cout <= s2_cout;
            gg   <= s2_gg;
            pg   <= s2_pg;
            ovf  <= f_ovf;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_cla_pipe_add.sv
// ============================================================================
// Module   : tb_cla_pipe_add
// Purpose  : Self-checking bench for cla_pipe_add (WIDTH=16, GROUP=4,
//            STAGES=2). The driver pushes the expected result of every
//            accepted beat into a queue. A separate monitor pops and compares
//            whenever a result is handed over.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cla_pipe_add;

    localparam int W  = 16;
    localparam int GR = 4;
    localparam int ST = 2;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid, in_ready;
    logic [W-1:0] a, b;
    logic         cin, sub;
    logic         out_valid, out_ready;
    logic [W-1:0] sum;
    logic         cout, gg, pg, ovf;

    cla_pipe_add #(.WIDTH(W), .GROUP(GR), .STAGES(ST)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .gg        (gg),
        .pg        (pg),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        logic [W-1:0] sum;
        logic [3:0]   flags;   // {cout, gg, pg, ovf}
        bit           lat;
        int           acc;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;
    bit   rnd_rdy = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h required %0h (t=%0t)", nm, act, req, $time);
        end
    endtask

    // Reference: plain integer addition of the effective operands.
    function automatic exp_t model(input logic [W-1:0] av, input logic [W-1:0] bv,
                                   input logic cv, input logic sv);
        exp_t         e;
        logic [W-1:0] be;
        logic         ce;
        logic [W:0]   full, nocin;
        logic         o;
        be    = sv ? ~bv : bv;
        ce    = sv ? 1'b1 : cv;
        full  = {1'b0, av} + {1'b0, be} + {{W{1'b0}}, ce};
        nocin = {1'b0, av} + {1'b0, be};
        o     = (av[W-1] == be[W-1]) && (full[W-1] != av[W-1]);
        e.sum = full[W-1:0];
`ifdef CLA_PIPE_SAT_EN
        if (o) e.sum = av[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
`endif
        e.flags = {full[W], nocin[W], &(av | be), o};
        e.lat   = 1'b0;
        e.acc   = 0;
        return e;
    endfunction

    // ---------------- monitor ----------------
    logic [W-1:0] h_sum;
    logic [3:0]   h_flags;
    bit           held = 0;

    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (!rst_n) begin
                held = 0;
            end else begin
                if (held && out_valid) begin
                    chk("hold_sum", sum, h_sum);
                    chk("hold_flags", {cout, gg, pg, ovf}, h_flags);
                end
                held = 0;
                if (out_valid && out_ready) begin
                    if (q.size() == 0) begin
                        chk("unexpected_out", 1, 0);
                    end else begin
                        exp_t e;
                        e = q.pop_front();
                        chk("sum", sum, e.sum);
                        chk("flags", {cout, gg, pg, ovf}, e.flags);
                        if (e.lat) chk("latency", cyc - e.acc, ST);
                    end
                end else if (out_valid) begin
                    held    = 1;
                    h_sum   = sum;
                    h_flags = {cout, gg, pg, ovf};
                end
            end
        end
    end

    // ---------------- driver ----------------
    // Called at a falling edge; returns at a later falling edge.
    task automatic send(input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic cv, input logic sv, input bit lat);
        bit done = 0;
        a = av; b = bv; cin = cv; sub = sv;
        in_valid = 1'b1;
        for (int n = 0; n < 100 && !done; n++) begin
            if (rnd_rdy) out_ready = ($urandom_range(0, 3) != 0);
            #1;
            if (in_ready) begin
                exp_t e;
                e     = model(av, bv, cv, sv);
                e.lat = lat;
                e.acc = cyc;
                q.push_back(e);
                done = 1;
            end
            @(negedge clk);
        end
        if (!done) chk("accept_timeout", 0, 1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int n = 0; n < 60 && q.size() != 0; n++) @(negedge clk);
        if (q.size() != 0) begin
            chk("drain_timeout", q.size(), 0);
            q.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        #200000;
        bad++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        logic [W-1:0] spec_v [5];
        int           idx;
        spec_v = '{16'h0000, 16'hFFFF, 16'h7FFF, 16'h8000, 16'h0001};

        rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_sum", sum, 0);
        chk("rst_flags", {cout, gg, pg, ovf}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready", in_ready, 1);
        @(negedge clk);

        // Directed cases, isolated beats so latency is checked too.
        send(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1); drain();
        send(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1); drain();
        send(16'h0005, 16'h0007, 1'b0, 1'b1, 1); drain();
        send(16'h0007, 16'h0005, 1'b0, 1'b1, 1); drain();
        send(16'h00FF, 16'hFF00, 1'b0, 1'b0, 1); drain();
        send(16'h00FF, 16'hFF00, 1'b1, 1'b0, 1); drain();
        send(16'h8000, 16'h8000, 1'b0, 1'b0, 1); drain();
        send(16'h8000, 16'h0001, 1'b1, 1'b1, 1); drain();

        // Random stream with random backpressure and gaps.
        rnd_rdy = 1;
        for (int i = 0; i < 300; i++) begin
            logic [W-1:0] ra, rb;
            ra = ($urandom_range(0, 3) == 0) ? spec_v[$urandom_range(0, 4)] : W'($urandom);
            rb = ($urandom_range(0, 3) == 0) ? spec_v[$urandom_range(0, 4)] : W'($urandom);
            send(ra, rb, 1'($urandom), 1'($urandom), 0);
            repeat ($urandom_range(0, 2)) begin
                out_ready = ($urandom_range(0, 3) != 0);
                @(negedge clk);
            end
        end
        rnd_rdy   = 0;
        out_ready = 1'b1;
        drain();

        // Full pipeline: out_ready low for 3 cycles, 6 beats offered back to back.
        idx = 0;
        for (int c = 0; c < 40 && idx < 6; c++) begin
            out_ready = (c >= 3);
            a = W'(16'h1111 * (idx + 1)); b = W'(16'h0101 * (idx + 1));
            cin = 1'b0; sub = 1'b0;
            in_valid = 1'b1;
            #1;
            if (c < 2) chk("stall_in_ready_open", in_ready, 1);
            if (c == 2) chk("stall_in_ready_full", in_ready, 0);
            if (c == 3) chk("accept_and_drain", in_ready, 1);
            if (in_ready) begin
                exp_t e;
                e = model(a, b, cin, sub);
                q.push_back(e);
                idx++;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        chk("stall_beats_sent", idx, 6);
        drain();

        // Reset with two beats in flight.
        out_ready = 1'b0;
        send(16'h1234, 16'h4321, 1'b0, 1'b0, 0);
        send(16'hAAAA, 16'h5555, 1'b1, 1'b0, 0);
        #3;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_sum", sum, 0);
        chk("midrst_flags", {cout, gg, pg, ovf}, 0);
        q.delete();
        repeat (2) @(negedge clk);
        #3;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        repeat (6) begin
            @(negedge clk);
            #1;
            chk("no_stale_out", out_valid, 0);
        end
        @(negedge clk);

        // Pipeline still works after the mid-stream reset.
        send(16'h0003, 16'h0004, 1'b1, 1'b0, 1); drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
